// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency MIPS data-memory responder with sign-extended loads.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned half/word accesses as errors instead of aligning them.
`default_nettype none

module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        Clock,
  input  logic        Reset_n,
  input  logic        Req_Valid,
  output logic        Req_Ready,
  input  logic        Req_Write,
  input  logic [1:0]  Req_Width,
  input  logic [31:0] Req_Addr,
  input  logic [31:0] Req_WData,
  output logic        Resp_Valid,
  input  logic        Resp_Ready,
  output logic [31:0] Resp_RData,
  output logic        Resp_Error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(LATENCY + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_HALF = 2'b01;
  localparam logic [1:0] W_BYTE = 2'b10;

  localparam logic [CW-1:0] CNT_LOAD = CW'(LATENCY - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          req_write;
  logic [1:0]    req_width;
  logic [1:0]    req_off;
  logic [AW-1:0] req_index;
  logic [31:0]   req_wdata;

  logic          access_err;
  logic [1:0]    lane;
  logic          commit;
  logic [31:0]   cur_word;
  logic [31:0]   store_word;
  logic [31:0]   load_word;
  logic [7:0]    load_byte;
  logic [15:0]   load_half;
  logic          unused_addr;

  logic [31:0]   mem [DEPTH];

  // Upper address bits only alias the array, so they never reach the datapath.
  assign unused_addr = ^Req_Addr[31:AW+2];

  assign Req_Ready  = (state == IDLE) && Reset_n;
  assign Resp_Valid = (state == RESP);
  assign commit     = (state == BUSY) && (cnt == '0);

  always_comb begin
    lane       = req_off;
    access_err = (req_width == 2'b11);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (req_width == W_WORD && req_off != 2'b00) access_err = 1'b1;
    if (req_width == W_HALF && req_off[0])       access_err = 1'b1;
`else
    if (req_width == W_WORD) lane = 2'b00;
    if (req_width == W_HALF) lane = {req_off[1], 1'b0};
`endif
  end

  assign cur_word  = mem[req_index];
  assign load_byte = cur_word[{lane, 3'b000} +: 8];
  assign load_half = cur_word[{lane[1], 4'b0000} +: 16];

  always_comb begin
    store_word = cur_word;
    load_word  = '0;
    case (req_width)
      W_WORD: begin
        store_word = req_wdata;
        load_word  = cur_word;
      end
      W_HALF: begin
        store_word[{lane[1], 4'b0000} +: 16] = req_wdata[15:0];
        load_word = {{16{load_half[15]}}, load_half};
      end
      W_BYTE: begin
        store_word[{lane, 3'b000} +: 8] = req_wdata[7:0];
        load_word = {{24{load_byte[7]}}, load_byte};
      end
      default: begin
        store_word = cur_word;
        load_word  = '0;
      end
    endcase
  end

  // The array carries no reset; the async reset forces state out of BUSY, so no commit can follow it.
  always_ff @(posedge Clock) begin
    if (commit && req_write && !access_err) mem[req_index] <= store_word;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      req_write  <= 1'b0;
      req_width  <= 2'b00;
      req_off    <= 2'b00;
      req_index  <= '0;
      req_wdata  <= '0;
      Resp_RData <= '0;
      Resp_Error <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (Req_Valid) begin
            req_write <= Req_Write;
            req_width <= Req_Width;
            req_off   <= Req_Addr[1:0];
            req_index <= Req_Addr[AW+1:2];
            req_wdata <= Req_WData;
            cnt       <= CNT_LOAD;
            state     <= BUSY;
          end
        end
        BUSY: begin
          if (cnt == '0) begin
            Resp_Error <= access_err;
            Resp_RData <= (req_write || access_err) ? 32'h0 : load_word;
            state      <= RESP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          if (Resp_Ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed and randomized checks of data_mem_responder against a word-array model.
`default_nettype none

module tb_data_mem_responder;

  localparam int DEPTH   = 1024;
  localparam int LATENCY = 2;

  logic        Clock = 1'b0;
  logic        Reset_n = 1'b0;
  logic        Req_Valid = 1'b0;
  logic        Req_Ready;
  logic        Req_Write = 1'b0;
  logic [1:0]  Req_Width = 2'b00;
  logic [31:0] Req_Addr = 32'h0;
  logic [31:0] Req_WData = 32'h0;
  logic        Resp_Valid;
  logic        Resp_Ready = 1'b0;
  logic [31:0] Resp_RData;
  logic        Resp_Error;

  data_mem_responder #(.DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .Clock      (Clock),
    .Reset_n    (Reset_n),
    .Req_Valid  (Req_Valid),
    .Req_Ready  (Req_Ready),
    .Req_Write  (Req_Write),
    .Req_Width  (Req_Width),
    .Req_Addr   (Req_Addr),
    .Req_WData  (Req_WData),
    .Resp_Valid (Resp_Valid),
    .Resp_Ready (Resp_Ready),
    .Resp_RData (Resp_RData),
    .Resp_Error (Resp_Error)
  );

  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  always @(posedge Clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference memory: a plain word array updated when a response is produced.
  logic [31:0] mm [DEPTH] = '{default: 32'h0};

  function automatic void model_exec(input logic w, input logic [1:0] wd, input logic [31:0] a,
                                     input logic [31:0] d, output logic [31:0] rd, output logic er);
    int idx;
    int sh;
    int v;
    logic [31:0] cur;
    logic [31:0] mask;
    idx = int'((a / 4) % DEPTH);
    sh  = int'(a % 4);
    cur = mm[idx];
    er  = (wd == 2'd3);
`ifdef DMEM_MISALIGN_CHECK_EN
    if (wd == 2'd0 && sh != 0) er = 1'b1;
    if (wd == 2'd1 && sh % 2 == 1) er = 1'b1;
`else
    if (wd == 2'd0) sh = 0;
    if (wd == 2'd1) sh = sh - sh % 2;
`endif
    rd = 32'h0;
    if (er) return;
    mask = (wd == 2'd0) ? 32'hFFFF_FFFF : (wd == 2'd1) ? 32'h0000_FFFF : 32'h0000_00FF;
    if (w) begin
      mm[idx] = (cur & ~(mask << (8 * sh))) | ((d & mask) << (8 * sh));
    end else begin
      v = int'((cur >> (8 * sh)) & mask);
      if (wd == 2'd1 && v >= 32768) v -= 65536;
      if (wd == 2'd2 && v >= 128) v -= 256;
      rd = 32'(v);
    end
  endfunction

  // Cycle-level compare: one request in flight, response due LATENCY edges after acceptance.
  logic        m_pending = 1'b0;
  logic        m_committed = 1'b0;
  int          m_resp_at = 0;
  logic        m_w;
  logic [1:0]  m_wd;
  logic [31:0] m_a;
  logic [31:0] m_d;
  logic [31:0] m_rd;
  logic        m_er;
  logic        exp_valid;

  always @(negedge Clock) begin
    if (!Reset_n) begin
      check("rst_resp_valid", Resp_Valid, 0);
      check("rst_req_ready", Req_Ready, 0);
      check("rst_resp_rdata", Resp_RData, 0);
      check("rst_resp_error", Resp_Error, 0);
      m_pending = 1'b0;
    end else begin
      if (m_pending && !m_committed && cyc >= m_resp_at) begin
        model_exec(m_w, m_wd, m_a, m_d, m_rd, m_er);
        m_committed = 1'b1;
      end
      exp_valid = m_pending && m_committed;
      check("resp_valid", Resp_Valid, exp_valid);
      check("req_ready", Req_Ready, !m_pending);
      if (exp_valid) begin
        check("resp_rdata", Resp_RData, m_rd);
        check("resp_error", Resp_Error, m_er);
      end
      if (!m_pending && Req_Valid) begin
        m_pending   = 1'b1;
        m_committed = 1'b0;
        m_resp_at   = cyc + 1 + LATENCY;
        m_w  = Req_Write;
        m_wd = Req_Width;
        m_a  = Req_Addr;
        m_d  = Req_WData;
      end else if (exp_valid && Resp_Ready) begin
        m_pending = 1'b0;
      end
    end
  end

  // One complete transaction; called and returns just after a rising edge.
  task automatic xact(input logic w, input logic [1:0] wd, input logic [31:0] a, input logic [31:0] d,
                      input int hold, output logic [31:0] rd, output logic er);
    int n;
    int lat;
    n  = 0;
    rd = 'x;
    er = 1'bx;
    Req_Valid = 1'b1; Req_Write = w; Req_Width = wd; Req_Addr = a; Req_WData = d;
    Resp_Ready = 1'b0;
    while (!Req_Ready && n < 20) begin
      @(posedge Clock); #1; n++;
    end
    if (!Req_Ready) begin
      check("accept_timeout", Req_Ready, 1);
      Req_Valid = 1'b0;
      return;
    end
    @(posedge Clock); #1;
    Req_Valid = 1'b0;
    lat = 0;
    while (!Resp_Valid && lat < 20) begin
      @(posedge Clock); #1; lat++;
    end
    check("latency", lat, LATENCY);
    if (!Resp_Valid) return;
    rd = Resp_RData;
    er = Resp_Error;
    for (int i = 0; i < hold; i++) begin
      @(posedge Clock); #1;
      check("hold_valid", Resp_Valid, 1);
      check("hold_rdata", Resp_RData, rd);
      check("hold_req_ready", Req_Ready, 0);
    end
    Resp_Ready = 1'b1;
    @(posedge Clock); #1;
    Resp_Ready = 1'b0;
    check("release_valid", Resp_Valid, 0);
    check("release_req_ready", Req_Ready, 1);
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;

    repeat (3) @(posedge Clock);
    #1;
    check("in_reset_req_ready", Req_Ready, 0);
    Reset_n = 1'b1;
    #1;
    check("post_reset_valid", Resp_Valid, 0);
    check("post_reset_rdata", Resp_RData, 0);
    check("post_reset_ready", Req_Ready, 1);
    @(posedge Clock); #1;

    for (int i = 0; i < 16; i++) xact(1'b1, 2'b00, 32'(i * 4), 32'h0, 0, rd, er);

    xact(1'b1, 2'b00, 32'h10, 32'hDEADBEEF, 0, rd, er);
    check("store_word_rdata", rd, 32'h0);
    check("store_word_error", er, 0);
    xact(1'b0, 2'b00, 32'h10, 32'h0, 0, rd, er);
    check("load_word_10", rd, 32'hDEADBEEF);

    xact(1'b1, 2'b10, 32'h21, 32'h0000_0080, 0, rd, er);
    xact(1'b0, 2'b10, 32'h21, 32'h0, 0, rd, er);
    check("load_byte_21", rd, 32'hFFFFFF80);
    xact(1'b0, 2'b00, 32'h20, 32'h0, 0, rd, er);
    check("load_word_20", rd, 32'h00008000);
    xact(1'b0, 2'b01, 32'h22, 32'h0, 0, rd, er);
    check("load_half_22", rd, 32'h0);

    xact(1'b0, 2'b00, 32'h10, 32'h0, 5, rd, er);
    check("held_load_10", rd, 32'hDEADBEEF);

    xact(1'b1, 2'b11, 32'h10, 32'hFFFFFFFF, 0, rd, er);
    check("reserved_store_error", er, 1);
    xact(1'b0, 2'b11, 32'h10, 32'h0, 0, rd, er);
    check("reserved_load_error", er, 1);
    check("reserved_load_rdata", rd, 32'h0);

    xact(1'b1, 2'b00, 32'h13, 32'h12345678, 0, rd, er);
`ifdef DMEM_MISALIGN_CHECK_EN
    check("misaligned_store_error", er, 1);
    xact(1'b0, 2'b00, 32'h10, 32'h0, 0, rd, er);
    check("misaligned_load_10", rd, 32'hDEADBEEF);
`else
    check("misaligned_store_error", er, 0);
    xact(1'b0, 2'b00, 32'h10, 32'h0, 0, rd, er);
    check("misaligned_load_10", rd, 32'h12345678);
`endif

    xact(1'b1, 2'b00, 32'h24, 32'h11112222, 0, rd, er);
    Req_Valid = 1'b1; Req_Write = 1'b1; Req_Width = 2'b00; Req_Addr = 32'h24; Req_WData = 32'hCAFEF00D;
    @(posedge Clock); #1;
    Req_Valid = 1'b0;
    check("busy_req_ready", Req_Ready, 0);
    @(posedge Clock); #1;
    Reset_n = 1'b0;
    #1;
    check("mid_reset_valid", Resp_Valid, 0);
    check("mid_reset_ready", Req_Ready, 0);
    repeat (2) @(posedge Clock);
    #1;
    Reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge Clock); #1;
      check("no_resp_after_reset", Resp_Valid, 0);
    end
    xact(1'b0, 2'b00, 32'h24, 32'h0, 0, rd, er);
    check("discarded_store_24", rd, 32'h11112222);

    for (int i = 0; i < 4000; i++) begin
      Req_Valid  = ($urandom_range(0, 3) != 0);
      Req_Write  = 1'($urandom_range(0, 1));
      Req_Width  = 2'($urandom_range(0, 3));
      Req_Addr   = $urandom & 32'hFFFF_F03F;
      Req_WData  = $urandom;
      Resp_Ready = ($urandom_range(0, 2) != 0);
      @(posedge Clock); #1;
    end
    Req_Valid  = 1'b0;
    Resp_Ready = 1'b1;
    repeat (LATENCY + 4) @(posedge Clock);
    #1;
    Resp_Ready = 1'b0;

    for (int i = 0; i < 16; i++) xact(1'b0, 2'b00, 32'(i * 4), 32'h0, 0, rd, er);

    repeat (2) @(posedge Clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
